uart_rx_debug: RTL and testbench
================================

# uart_rx_debug

Receive-side counterpart of the debug UART transmitter: it deserialises an 8N1 asynchronous serial stream on the UART Rx pin into bytes for the control wrapper. The block synchronises the pin, qualifies the start bit at mid-bit, samples each data bit at its centre, and checks the stop bit. For each frame it emits either a one-cycle valid pulse with the byte or a one-cycle framing-error pulse. Default timing is 115200 baud from a 100 MHz clock.

## Interface
- clks_per_bit, 868, clock cycles per bit; legal range 4..1023 (10-bit counter)
- clk  in  1  system clock; all logic on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- Rx_Serial  in  1  raw serial input, asynchronous to clk; idles high
- Rx_Parallel  out  8  last correctly received byte; LSB is the first data bit on the wire
- Rx_Valid  out  1  one-cycle pulse: a new byte is on Rx_Parallel
- Rx_Error  out  1  one-cycle pulse: frame rejected because the stop bit sampled low
- Rx_Busy  out  1  high in every state except IDLE

## Operation
- Synchroniser: two flops on Rx_Serial, both reset to 1. All decisions use the second flop (rx_s) only.
- Counters: clk_count is 10 bits and resets to 0 on every state change. bitIndex is 3 bits. Shift register rx_shift is 8 bits.
- IDLE
  - When rx_s == 0, go to START with clk_count = 0.
  - Otherwise stay in IDLE.
- START
  - Count up until clk_count == (clks_per_bit-1)/2, using integer division (433 at default).
  - At that count, if rx_s == 0, go to DATA with bitIndex = 0.
  - If rx_s == 1, treat it as a glitch and return to IDLE. No pulse is issued.
- DATA
  - Count up until clk_count == clks_per_bit-1.
  - At that count, write rx_s into rx_shift[bitIndex].
  - After bitIndex 7 is written, go to STOP. Otherwise increment bitIndex.
- STOP
  - Count up until clk_count == clks_per_bit-1, then sample rx_s.
  - If rx_s == 1: load Rx_Parallel from rx_shift, pulse Rx_Valid, go to IDLE.
  - If rx_s == 0: pulse Rx_Error, leave Rx_Parallel unchanged, go to WAIT_HIGH.
- WAIT_HIGH
  - Stay here while rx_s == 0. This covers a held-low line or a break condition.
  - Go to IDLE on the first cycle rx_s == 1. Without this state, IDLE would treat the low line as a new start bit.
- Illegal state encodings go to IDLE.
- Rx_Valid and Rx_Error are never high in the same cycle. Each is high for exactly one cycle per frame.
- Reset values: Rx_Parallel = 0x00, Rx_Valid = 0, Rx_Error = 0, Rx_Busy = 0, state = IDLE, counters = 0, synchroniser = 1.
- Reset mid-frame: the frame is abandoned immediately and no pulse is issued. After release, reception restarts only on a fresh falling edge.

## Timing
- Pin to decision: 2 cycles of synchroniser latency.
- Let t0 be the first cycle in START.
  - Start-bit qualification sample: t0+433 (default).
  - Data bit k sample: t0+433+(k+1)*868.
  - Stop-bit sample: t0+433+9*868 = t0+8245.
  - Rx_Valid or Rx_Error is registered high at t0+8246.
- Stop sample falls mid stop bit, so the block is back in IDLE about 434 cycles before the stop bit ends. Back-to-back frames with zero idle time are therefore accepted.
- Tolerated baud mismatch is about ±4% cumulative over 9.5 bit times.
- Rx_Parallel is stable from the Rx_Valid cycle until the next Rx_Valid. The consumer samples it in or after the Rx_Valid cycle.
- There is no backpressure. A byte the wrapper does not consume is overwritten by the next valid frame.

## Structure
- Shared package uart_pkg holds:
  - the state encoding: IDLE = 0, START = 1, DATA = 2, STOP = 3, WAIT_HIGH = 4, shared with the transmitter's IDLE/START/DATA/STOP codes;
  - the default CLKS_PER_BIT = 868;
  - the data width of 8.
- One sub-module, uart_rx_sync: the two-flop, reset-to-1 synchroniser. The FSM, counters and output registers stay in uart_rx_debug.

## Test plan
- Send frame 0xA5 at clks_per_bit = 16 → Rx_Valid pulses once at t0+7+9*16+1, Rx_Parallel = 0xA5, Rx_Error never high.
- Drive a low glitch for 5 cycles at clks_per_bit = 16 → block returns to IDLE, no Rx_Valid or Rx_Error, Rx_Parallel unchanged.
- Send 0x3C with the stop bit driven low and the line held low for 40 more cycles, then raised and followed by 0x81 → Rx_Error pulses once, Rx_Parallel stays at the previous byte, then 0x81 is received with one Rx_Valid.
- Send back-to-back 0x00 then 0xFF with no idle gap → two Rx_Valid pulses, values 0x00 then 0xFF, no error.
- Assert rst_n low during bit 4 of a frame, release, then send 0x5A → no pulse for the aborted frame, outputs at reset values, 0x5A received correctly.
- Loop back the debug transmitter at the default 868 with bytes 0x00..0xFF → all 256 bytes received in order, Rx_Error never high.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: state codes, default timing and data width.
// The transmitter uses the same IDLE/START/DATA/STOP codes.
package uart_pkg;

    localparam int unsigned CLKS_PER_BIT = 868;
    localparam int unsigned DATA_W       = 8;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_HIGH = 3'd4
    } uart_state_e;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the asynchronous Rx pin.
// Both flops reset to 1 so an idle line is never seen as a start bit.
module uart_rx_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_d, meta_q;
    logic sync_d, sync_q;

    // next values: shift the pin through two stages
    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    // synchroniser flops, idle-high after reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/uart_rx_debug.sv
// 8N1 debug UART receiver: mid-bit sampling, stop-bit check,
// one-cycle valid or framing-error pulse per frame.
module uart_rx_debug
    import uart_pkg::*;
#(
    parameter int unsigned clks_per_bit = CLKS_PER_BIT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              Rx_Serial,
    output logic [DATA_W-1:0] Rx_Parallel,
    output logic              Rx_Valid,
    output logic              Rx_Error,
    output logic              Rx_Busy
);

    localparam logic [9:0] HALF = 10'((clks_per_bit - 1) / 2);
    localparam logic [9:0] LAST = 10'(clks_per_bit - 1);

    logic rx_s;

    uart_rx_sync u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (Rx_Serial),
        .q     (rx_s)
    );

    uart_state_e       state_d, state_q;
    logic [9:0]        cnt_d, cnt_q;
    logic [2:0]        idx_d, idx_q;
    logic [DATA_W-1:0] shift_d, shift_q;
    logic [DATA_W-1:0] data_d, data_q;
    logic              valid_d, valid_q;
    logic              err_d, err_q;
    logic              busy_d, busy_q;

    // frame FSM: next state, counters, shift register and output pulses
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 10'd1;
        idx_d   = idx_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = 1'b0;
        err_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (!rx_s) state_d = START;
            end
            START: begin
                if (cnt_q == HALF) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt_q == LAST) begin
                    cnt_d          = '0;
                    shift_d[idx_q] = rx_s;
                    if (idx_q == 3'd7) state_d = STOP;
                    else               idx_d   = idx_q + 3'd1;
                end
            end
            STOP: begin
                if (cnt_q == LAST) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                        state_d = IDLE;
                    end else begin
                        err_d   = 1'b1;
                        state_d = WAIT_HIGH;
                    end
                end
            end
            WAIT_HIGH: begin
                cnt_d = '0;
                if (rx_s) state_d = IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // state and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
        end
    end

    assign Rx_Parallel = data_q;
    assign Rx_Valid    = valid_q;
    assign Rx_Error    = err_q;
    assign Rx_Busy     = busy_q;

endmodule

// File: tb/tb_uart_rx_debug.sv
// Bench for uart_rx_debug at 16 clocks per bit.
// A serial model drives frames; a monitor pops expected results on each pulse.
module tb_uart_rx_debug;

    localparam int CPB = 16;
    // start edge driven -> pulse visible: 2 sync + 1 idle + 7 + 9*16 + 1
    localparam int LAT = 155;

    typedef struct {
        bit         err;
        logic [7:0] data;
        int         at;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       Rx_Serial = 1'b1;
    logic [7:0] Rx_Parallel;
    logic       Rx_Valid;
    logic       Rx_Error;
    logic       Rx_Busy;

    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    logic [7:0] last_byte = 8'h00;
    exp_t       sb[$];

    uart_rx_debug #(.clks_per_bit(CPB)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .Rx_Serial   (Rx_Serial),
        .Rx_Parallel (Rx_Parallel),
        .Rx_Valid    (Rx_Valid),
        .Rx_Error    (Rx_Error),
        .Rx_Busy     (Rx_Busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // monitor: every pulse must match the head of the scoreboard
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && (Rx_Valid || Rx_Error)) begin
            checks++;
            if (Rx_Valid && Rx_Error) begin
                errors++;
                $display("FAIL both_pulses: valid=%b error=%b required one", Rx_Valid, Rx_Error);
            end
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pulse: valid=%b error=%b at cyc %0d", Rx_Valid, Rx_Error, cyc);
            end else begin
                e = sb.pop_front();
                checks++;
                if (Rx_Error !== e.err) begin
                    errors++;
                    $display("FAIL pulse_kind: error=%b required %b", Rx_Error, e.err);
                end
                checks++;
                if (cyc !== e.at) begin
                    errors++;
                    $display("FAIL pulse_time: cyc=%0d required %0d", cyc, e.at);
                end
                checks++;
                if (!e.err) begin
                    if (Rx_Parallel !== e.data) begin
                        errors++;
                        $display("FAIL rx_data: got %h required %h", Rx_Parallel, e.data);
                    end
                    last_byte = e.data;
                end else if (Rx_Parallel !== last_byte) begin
                    errors++;
                    $display("FAIL data_on_error: got %h required %h", Rx_Parallel, last_byte);
                end
            end
        end
    end

    task automatic idle(input int n);
        Rx_Serial = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic drive_bit(input logic v);
        Rx_Serial = v;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        exp_t e;
        e.err  = !stop;
        e.data = b;
        e.at   = cyc + LAT;
        sb.push_back(e);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        drive_bit(stop);
    endtask

    task automatic check_drained(input string name);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: %0d pulses missing, required 0", name, sb.size());
            sb.delete();
        end
    endtask

    task automatic test_reset();
        checks++;
        if ({Rx_Parallel, Rx_Valid, Rx_Error, Rx_Busy} !== 11'h0) begin
            errors++;
            $display("FAIL reset_values: data=%h v=%b e=%b b=%b required 00 0 0 0",
                     Rx_Parallel, Rx_Valid, Rx_Error, Rx_Busy);
        end
        rst_n = 1'b1;
        idle(5);
        checks++;
        if (Rx_Busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_busy: got %b required 0", Rx_Busy);
        end
    endtask

    task automatic test_frame();
        send_frame(8'hA5, 1'b1);
        check_drained("frame_a5");
        checks++;
        if (Rx_Parallel !== 8'hA5) begin
            errors++;
            $display("FAIL frame_hold: got %h required a5", Rx_Parallel);
        end
        idle(10);
    endtask

    task automatic test_glitch();
        Rx_Serial = 1'b0;
        repeat (5) @(negedge clk);
        idle(30);
        checks++;
        if (Rx_Busy !== 1'b0) begin
            errors++;
            $display("FAIL glitch_busy: got %b required 0", Rx_Busy);
        end
        checks++;
        if (Rx_Parallel !== 8'hA5) begin
            errors++;
            $display("FAIL glitch_data: got %h required a5", Rx_Parallel);
        end
        check_drained("glitch");
    endtask

    task automatic test_framing_error();
        send_frame(8'h3C, 1'b0);
        Rx_Serial = 1'b0;
        repeat (40) @(negedge clk);
        checks++;
        if (Rx_Busy !== 1'b1) begin
            errors++;
            $display("FAIL wait_high_busy: got %b required 1", Rx_Busy);
        end
        check_drained("err_3c");
        checks++;
        if (Rx_Parallel !== 8'hA5) begin
            errors++;
            $display("FAIL err_data: got %h required a5", Rx_Parallel);
        end
        idle(10);
        send_frame(8'h81, 1'b1);
        idle(5);
        check_drained("after_err");
    endtask

    task automatic test_back_to_back();
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        idle(5);
        check_drained("b2b");
    endtask

    task automatic test_reset_mid_frame();
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(1'b0);
        Rx_Serial = 1'b0;
        repeat (8) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({Rx_Parallel, Rx_Valid, Rx_Error, Rx_Busy} !== 11'h0) begin
            errors++;
            $display("FAIL midreset_values: data=%h v=%b e=%b b=%b required 00 0 0 0",
                     Rx_Parallel, Rx_Valid, Rx_Error, Rx_Busy);
        end
        last_byte = 8'h00;
        Rx_Serial = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        idle(20);
        check_drained("midreset");
        send_frame(8'h5A, 1'b1);
        idle(5);
        check_drained("after_reset");
    endtask

    task automatic test_loopback();
        for (int i = 0; i < 256; i++) send_frame(8'(i), 1'b1);
        idle(5);
        check_drained("loopback");
        checks++;
        if (Rx_Parallel !== 8'hFF) begin
            errors++;
            $display("FAIL loopback_last: got %h required ff", Rx_Parallel);
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        test_reset();
        test_frame();
        test_glitch();
        test_framing_error();
        test_back_to_back();
        test_reset_mid_frame();
        test_loopback();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
